// File: rtl/ws2812_drive.sv
// ws2812_drive: WS2812 NRZ serial transmitter for an 8x8 LED matrix.
// Walks NUM_PIXEL x 24 bit slots, asks the colour lookup for each bit via
// cnt_pixel/cnt_bit, encodes it as a high pulse of T1H_CYC or T0H_CYC
// cycles in a BIT_CYC slot, then holds the line low for RST_CYC cycles.
// Optional feature macro: WS2812_AUTO_REFRESH_EN (free-running refresh,
// frame_start ignored, LATCH loops straight back into SEND).
module ws2812_drive #(
   parameter int BIT_CYC   = 60,
   parameter int T0H_CYC   = 15,
   parameter int T1H_CYC   = 30,
   parameter int RST_CYC   = 15000,
   parameter int NUM_PIXEL = 64
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       frame_start,
   input  logic       bit_in,
   output logic [4:0] cnt_bit,
   output logic [6:0] cnt_pixel,
   output logic       dout,
   output logic       busy,
   output logic       frame_done
);

   localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int LAT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYC - 1);
   localparam logic [CYC_W-1:0] T0H_VAL   = CYC_W'(T0H_CYC);
   localparam logic [CYC_W-1:0] T1H_VAL   = CYC_W'(T1H_CYC);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RST_CYC - 1);
   localparam logic [6:0]       PIX_LAST  = 7'(NUM_PIXEL - 1);
   localparam logic [4:0]       BIT_LAST  = 5'd23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t           state_reg,     state_next;
   logic [CYC_W-1:0] cnt_cyc_reg,   cnt_cyc_next;
   logic [LAT_W-1:0] cnt_lat_reg,   cnt_lat_next;
   logic [4:0]       cnt_bit_reg,   cnt_bit_next;
   logic [6:0]       cnt_pixel_reg, cnt_pixel_next;
   logic             cur_bit_reg,   cur_bit_next;
   logic             dout_reg,      dout_next;
   logic             slot_bit;

`ifdef WS2812_AUTO_REFRESH_EN
   // Refresh is free-running, so the request input has no effect.
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
`endif

   // Next-state, counter and pulse-shaping logic.
   always_comb begin
      state_next     = state_reg;
      cnt_cyc_next   = cnt_cyc_reg;
      cnt_lat_next   = cnt_lat_reg;
      cnt_bit_next   = cnt_bit_reg;
      cnt_pixel_next = cnt_pixel_reg;
      cur_bit_next   = cur_bit_reg;
      dout_next      = 1'b0;
      frame_done     = 1'b0;
      // On the first cycle of a slot the captured bit is not ready yet,
      // so the live lookup value decides the pulse width.
      slot_bit       = (cnt_cyc_reg == '0) ? bit_in : cur_bit_reg;

      case (state_reg)
         IDLE: begin
            cnt_cyc_next   = '0;
            cnt_lat_next   = '0;
            cnt_bit_next   = '0;
            cnt_pixel_next = '0;
`ifdef WS2812_AUTO_REFRESH_EN
            state_next = SEND;
`else
            if (frame_start) begin
               state_next = SEND;
            end
`endif
         end

         SEND: begin
            if (cnt_cyc_reg == '0) begin
               cur_bit_next = bit_in;
            end
            dout_next = (cnt_cyc_reg < (slot_bit ? T1H_VAL : T0H_VAL));

            if (cnt_cyc_reg == CYC_LAST) begin
               cnt_cyc_next = '0;
               if (cnt_bit_reg == BIT_LAST) begin
                  cnt_bit_next = '0;
                  if (cnt_pixel_reg == PIX_LAST) begin
                     cnt_pixel_next = '0;
                     cnt_lat_next   = '0;
                     state_next     = LATCH;
                  end else begin
                     cnt_pixel_next = cnt_pixel_reg + 7'd1;
                  end
               end else begin
                  cnt_bit_next = cnt_bit_reg + 5'd1;
               end
            end else begin
               cnt_cyc_next = cnt_cyc_reg + 1'b1;
            end
         end

         LATCH: begin
            if (cnt_lat_reg == LAT_LAST) begin
               frame_done   = 1'b1;
               cnt_lat_next = '0;
               cnt_cyc_next = '0;
`ifdef WS2812_AUTO_REFRESH_EN
               state_next = SEND;
`else
               state_next = IDLE;
`endif
            end else begin
               cnt_lat_next = cnt_lat_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset takes effect immediately.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg     <= IDLE;
         cnt_cyc_reg   <= '0;
         cnt_lat_reg   <= '0;
         cnt_bit_reg   <= '0;
         cnt_pixel_reg <= '0;
         cur_bit_reg   <= 1'b0;
         dout_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_cyc_reg   <= cnt_cyc_next;
         cnt_lat_reg   <= cnt_lat_next;
         cnt_bit_reg   <= cnt_bit_next;
         cnt_pixel_reg <= cnt_pixel_next;
         cur_bit_reg   <= cur_bit_next;
         dout_reg      <= dout_next;
      end
   end

   assign cnt_bit   = cnt_bit_reg;
   assign cnt_pixel = cnt_pixel_reg;
   assign dout      = dout_reg;
   assign busy      = (state_reg != IDLE);

endmodule
